// File: rtl/kgp_mem_pkg.sv
// Shared types and constants for the LSU data-memory controller.
package kgp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int DEFAULT_MEM_AW = 10;

  // Word index is req_addr[MEM_AW+WORD_LSB-1 : WORD_LSB]; bits below are the byte offset.
  localparam int WORD_LSB = 2;

  // Wide enough for the largest legal read latency (3).
  localparam int CNT_W = 2;

endpackage

// File: rtl/lsu_lat_cnt.sv
// Loadable down-counter that times the read-wait window of the LSU controller.
module lsu_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller between a core request port and DataMem port A.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned byte addresses are answered with an error.
module lsu_mem_ctrl
  import kgp_mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int MEM_AW = DEFAULT_MEM_AW
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  input  logic              resp_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output state_t            state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready. Both
  // valids never depend combinationally on the opposite side's ready.

  state_t      state_nxt;
  logic        accept;
  logic        out_of_range;
  logic        addr_err;
  logic        cnt_zero;
  logic [31:0] addr_hi;

  assign addr_hi      = req_addr >> (MEM_AW + WORD_LSB);
  assign out_of_range = (addr_hi != 32'd0);

`ifdef LSU_ALIGN_CHECK_EN
  assign addr_err = out_of_range | (req_addr[WORD_LSB-1:0] != '0);
`else
  assign addr_err = out_of_range;
`endif

  assign accept = req_valid && req_ready;

  lsu_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk      (clka),
    .rst_n    (rsta),
    .load     (accept && !addr_err && !req_we),
    .load_val (CNT_W'(RD_LAT)),
    .dec      (state == RD_WAIT),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clka) begin
    if (!rsta) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (addr_err)    state_nxt = RESP;
          else if (req_we) state_nxt = WR;
          else             state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt_zero) state_nxt = RESP;
      WR:      state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_we is gated by rsta so a store caught by reset never commits its write.
  always_comb begin
    req_ready  = (state == IDLE) && rsta;
    resp_valid = (state == RESP);
    mem_we     = (state == WR) && rsta;
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        resp_err   <= addr_err;
        resp_rdata <= '0;
        if (!addr_err) begin
          mem_addr <= req_addr[MEM_AW+WORD_LSB-1:WORD_LSB];
          mem_din  <= req_wdata;
        end
      end
      if ((state == RD_WAIT) && cnt_zero) begin
        resp_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, randomized traffic against a word-array model, reset and back-to-back sequences.
module tb_lsu_mem_ctrl;
  import kgp_mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rsta;
  logic              req_valid, req_we;
  logic [31:0]       req_addr, req_wdata;
  logic              req_ready, resp_valid, resp_err, resp_ready;
  logic [31:0]       resp_rdata;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_din, mem_dout;
  state_t            dbg_state;

  int checks = 0;
  int failures = 0;

  lsu_mem_ctrl #(.RD_LAT(RD_LAT), .MEM_AW(MEM_AW)) dut (
    .clka       (clk),
    .rsta       (rsta),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .resp_ready (resp_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DataMem model (RD_LAT-cycle synchronous read) ----------------
  logic [31:0] ram [DEPTH];
  logic [31:0] rd_pipe [RD_LAT];
  int          we_cnt = 0;
  logic [MEM_AW-1:0] last_we_addr;
  logic [31:0]       last_we_din;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_din;
      we_cnt       = we_cnt + 1;
      last_we_addr = mem_addr;
      last_we_din  = mem_din;
    end
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];

  function automatic logic model_err(input logic [31:0] a);
    logic e;
    e = (a >> (MEM_AW + 2)) != 32'd0;
`ifdef LSU_ALIGN_CHECK_EN
    if (a % 4 != 0) e = 1'b1;
`endif
    return e;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  function automatic vec_t model_vec(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int hold);
    vec_t v;
    int   idx;
    v.we = we; v.addr = addr; v.wdata = wdata; v.hold = hold;
    v.exp_err = model_err(addr);
    idx = int'(addr / 4) % DEPTH;
    if (v.exp_err) begin
      v.exp_rdata = 32'd0; v.exp_lat = 1;
    end else if (we) begin
      v.exp_rdata = 32'd0; v.exp_lat = 2;
    end else begin
      v.exp_rdata = ref_mem[idx]; v.exp_lat = RD_LAT + 2;
    end
    return v;
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [31:0] rdata;
    logic        err;
    int          lat, base, idx;
    check({name, "_ready_before"}, 32'(req_ready), 32'd1);
    base = we_cnt;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(lat);
    rdata = resp_rdata; err = resp_err;
    check({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    check({name, "_err"}, 32'(err), 32'(v.exp_err));
    exp_q.push_back(v.exp_rdata);
    check({name, "_rdata"}, rdata, exp_q.pop_front());
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({name, "_hold_rdata"}, resp_rdata, v.exp_rdata);
      check({name, "_hold_err"}, 32'(resp_err), 32'(v.exp_err));
      check({name, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, "_idle_after"}, 32'(req_ready), 32'd1);
    check({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    if (v.we && !v.exp_err) begin
      idx = int'(v.addr / 4) % DEPTH;
      check({name, "_we_pulses"}, 32'(we_cnt - base), 32'd1);
      check({name, "_we_addr"}, 32'(last_we_addr), 32'(idx));
      check({name, "_we_din"}, last_we_din, v.wdata);
      ref_mem[idx] = v.wdata;
    end else begin
      check({name, "_we_pulses"}, 32'(we_cnt - base), 32'd0);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs [12];

  initial begin
    vec_t        v;
    int          lat;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rsta = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    rsta = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // directed vectors: {we, addr, wdata, hold, exp_err, exp_rdata, exp_lat}
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'h0000_0005, 0, 1'b0, 32'h0, 2};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         0, 1'b0, 32'h5, RD_LAT + 2};
    vecs[2]  = '{1'b0, 32'h0001_0000, 32'h0,         0, 1'b1, 32'h0, 1};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'hCAFE_0001, 0, 1'b0, 32'h0, 2};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         5, 1'b0, 32'hCAFE_0001, RD_LAT + 2};
`ifdef LSU_ALIGN_CHECK_EN
    vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0,         0, 1'b1, 32'h0, 1};
    vecs[10] = '{1'b1, 32'h0000_0009, 32'h77,        0, 1'b1, 32'h0, 1};
    vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         0, 1'b0, 32'h5, RD_LAT + 2};
`else
    vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0,         0, 1'b0, 32'hCAFE_0001, RD_LAT + 2};
    vecs[10] = '{1'b1, 32'h0000_0009, 32'h77,        0, 1'b0, 32'h0, 2};
    vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         0, 1'b0, 32'h77, RD_LAT + 2};
`endif
    vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 1, 1'b0, 32'h0, 2};
    vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         2, 1'b0, 32'h1234_5678, RD_LAT + 2};
    vecs[8]  = '{1'b1, 32'h0000_1000, 32'h0000_DEAD, 0, 1'b1, 32'h0, 1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         0, 1'b0, 32'h0, RD_LAT + 2};
    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = (32'($urandom_range(0, 31)) << 2) | ($urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'd0);
      v = model_vec(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      run_vec($sformatf("rnd%0d", i), v);
    end

    // reset during WR abandons the store
    run_vec("pre_rst_store", model_vec(1'b1, 32'h20, 32'h1111_1111, 0));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h2222_2222;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_state", 32'(dbg_state), 32'(WR));
    check("wr_mem_we", 32'(mem_we), 32'd1);
    rsta = 1'b0;
    @(negedge clk);
    check("wr_rst_mem_we", 32'(mem_we), 32'd0);
    check("wr_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("wr_rst_req_ready", 32'(req_ready), 32'd0);
    rsta = 1'b1;
    @(negedge clk);
    check("wr_rel_req_ready", 32'(req_ready), 32'd1);
    check("wr_rel_resp_valid", 32'(resp_valid), 32'd0);
    run_vec("post_rst_load", model_vec(1'b0, 32'h20, 32'h0, 0));

    // back-to-back loads with req_valid held high
    run_vec("b2b_st0", model_vec(1'b1, 32'h8, 32'hAAAA_0002, 0));
    run_vec("b2b_st1", model_vec(1'b1, 32'hC, 32'hBBBB_0003, 0));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8;
    @(negedge clk);
    req_addr = 32'hC;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      check("b2b_blocked", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("b2b_first_lat", 32'(lat), 32'(RD_LAT + 2));
    check("b2b_first_rdata", resp_rdata, 32'hAAAA_0002);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_ready_after_hs", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_taken", 32'(dbg_state), 32'(RD_WAIT));
    check("b2b_second_busy", 32'(req_ready), 32'd0);
    wait_resp(lat);
    check("b2b_second_lat", 32'(lat), 32'(RD_LAT + 2));
    check("b2b_second_rdata", resp_rdata, 32'hBBBB_0003);
    check("b2b_second_err", 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("b2b_idle", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
